// File: rtl/reset_sequencer.sv
// Reset sequencer: holds core, peripheral and IO resets asserted until the reset
// requests have been quiet for HOLD_CYCLES, then releases them in order (core,
// peripheral, IO), spaced GAP_CYCLES apart, before signalling ready.
//
// Ports
//   clk_i        single clock, all state on its rising edge
//   rst_i        asynchronous active-high reset
//   ext_rst_i    asynchronous active-high external reset request (synchronised)
//   soft_rst_i   synchronous active-high software reset request
//   rst_core_o   core reset, released first
//   rst_periph_o peripheral reset, released second
//   rst_io_o     IO reset, released last
//   ready_o      high only in RUN
//   state_o      state encoding (HOLD=0 .. RUN=4)
//   evt_cnt_o    saturating count of re-entries into HOLD
module reset_sequencer #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned GAP_CYCLES  = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ext_rst_i,
    input  logic             soft_rst_i,
    output logic             rst_core_o,
    output logic             rst_periph_o,
    output logic             rst_io_o,
    output logic             ready_o,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] evt_cnt_o
);

    typedef enum logic [2:0] {
        StHold      = 3'd0,
        StRelCore   = 3'd1,
        StRelPeriph = 3'd2,
        StRelIo     = 3'd3,
        StRun       = 3'd4
    } state_e;

    localparam int unsigned MaxCycles = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);
    localparam logic [CntW-1:0] GapLast  = CntW'(GAP_CYCLES - 1);

    logic [SYNC_STAGES-1:0] ext_sync_q;
    logic                   ext_sync;
    logic                   req;
    logic                   evt_inc;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   rst_core_q, rst_periph_q, rst_io_q, ready_q;
    logic [CNT_W-1:0]       evt_q;

    // External request synchroniser; only this input crosses a clock boundary.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ext_sync_q <= '0;
        end else begin
            ext_sync_q <= {ext_sync_q[SYNC_STAGES-2:0], ext_rst_i};
        end
    end

    assign ext_sync = ext_sync_q[SYNC_STAGES-1];
    assign req      = ext_sync | soft_rst_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StHold: begin
                // Any request restarts the quiet-period count.
                if (req) begin
                    cnt_d = '0;
                end else if (cnt_q == HoldLast) begin
                    state_d = StRelCore;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StRelCore, StRelPeriph, StRelIo: begin
                if (req) begin
                    state_d = StHold;
                    cnt_d   = '0;
                end else if (cnt_q == GapLast) begin
                    cnt_d = '0;
                    if (state_q == StRelCore) begin
                        state_d = StRelPeriph;
                    end else if (state_q == StRelPeriph) begin
                        state_d = StRelIo;
                    end else begin
                        state_d = StRun;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StRun: begin
                if (req) begin
                    state_d = StHold;
                    cnt_d   = '0;
                end
            end
            default: begin
                // Unused encodings recover into HOLD.
                state_d = StHold;
                cnt_d   = '0;
            end
        endcase
    end

    // One event per request-driven fall back into HOLD, however many sources fired.
    assign evt_inc = req && (state_q != StHold) && (state_d == StHold);

    // Outputs decoded from next state so they switch on the same edge as state_q.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StHold;
            cnt_q        <= '0;
            rst_core_q   <= 1'b1;
            rst_periph_q <= 1'b1;
            rst_io_q     <= 1'b1;
            ready_q      <= 1'b0;
            evt_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rst_core_q   <= (state_d == StHold);
            rst_periph_q <= (state_d == StHold) || (state_d == StRelCore);
            rst_io_q     <= (state_d == StHold) || (state_d == StRelCore) ||
                            (state_d == StRelPeriph);
            ready_q      <= (state_d == StRun);
            if (evt_inc && (evt_q != '1)) begin
                evt_q <= evt_q + CNT_W'(1);
            end
        end
    end

    assign rst_core_o   = rst_core_q;
    assign rst_periph_o = rst_periph_q;
    assign rst_io_o     = rst_io_q;
    assign ready_o      = ready_q;
    assign state_o      = state_q;
    assign evt_cnt_o    = evt_q;

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ext_rst = 1'b0;
    logic       soft_rst = 1'b0;
    logic       rst_core, rst_periph, rst_io, ready;
    logic [2:0] state;
    logic [7:0] evt;

    logic       s_core, s_periph, s_io, s_ready;
    logic [2:0] s_state;
    logic [1:0] s_evt;

    int errors = 0;
    int checks = 0;

    logic [14:0] exp_q[$];
    logic [1:0]  sat_q[$];

    wire [14:0] obs = {rst_core, rst_periph, rst_io, ready, state, evt};

    always #5 clk = ~clk;

    reset_sequencer dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .ext_rst_i    (ext_rst),
        .soft_rst_i   (soft_rst),
        .rst_core_o   (rst_core),
        .rst_periph_o (rst_periph),
        .rst_io_o     (rst_io),
        .ready_o      (ready),
        .state_o      (state),
        .evt_cnt_o    (evt)
    );

    reset_sequencer #(.CNT_W(2)) dut_sat (
        .clk_i        (clk),
        .rst_i        (rst),
        .ext_rst_i    (ext_rst),
        .soft_rst_i   (soft_rst),
        .rst_core_o   (s_core),
        .rst_periph_o (s_periph),
        .rst_io_o     (s_io),
        .ready_o      (s_ready),
        .state_o      (s_state),
        .evt_cnt_o    (s_evt)
    );

    // Expected output vector for a given state and event count.
    function automatic logic [14:0] exp_vec(input logic [2:0] st, input logic [7:0] ev);
        return {st == 3'd0, st <= 3'd1, st <= 3'd2, st == 3'd4, st, ev};
    endfunction

    // State after k request-free edges since entering HOLD (defaults 16/4/4/4).
    function automatic logic [2:0] seq_state(input int k);
        if (k < 16) return 3'd0;
        if (k < 20) return 3'd1;
        if (k < 24) return 3'd2;
        if (k < 28) return 3'd3;
        return 3'd4;
    endfunction

    task automatic test_reset();
        logic [14:0] e;
        @(negedge clk);
        rst = 1'b1;
        exp_q.push_back(exp_vec(3'd0, 8'd0));
        #1;
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", obs, e);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            exp_q.push_back(exp_vec(seq_state(i), 8'd0));
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL power_on_seq edge %0d: got %h expected %h", i, obs, e);
            end
        end
    endtask

    task automatic test_soft();
        logic [14:0] e;
        soft_rst = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            exp_q.push_back(i == 1 ? exp_vec(3'd0, 8'd1) : exp_vec(seq_state(i - 1), 8'd1));
            @(posedge clk);
            #1;
            soft_rst = 1'b0;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL soft_pulse edge %0d: got %h expected %h", i, obs, e);
            end
        end
    endtask

    task automatic test_ext();
        logic [14:0] e;
        ext_rst = 1'b1;
        for (int i = 1; i <= 37; i++) begin
            if (i < 3) exp_q.push_back(exp_vec(3'd4, 8'd1));
            else if (i < 8) exp_q.push_back(exp_vec(3'd0, 8'd2));
            else exp_q.push_back(exp_vec(seq_state(i - 7), 8'd2));
            @(posedge clk);
            #1;
            if (i == 5) ext_rst = 1'b0;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL ext_hold edge %0d: got %h expected %h", i, obs, e);
            end
        end
    endtask

    task automatic test_glitch();
        logic [14:0] e;
        soft_rst = 1'b1;
        for (int i = 1; i <= 55; i++) begin
            if (i == 1) exp_q.push_back(exp_vec(3'd0, 8'd3));
            else if (i < 25) exp_q.push_back(exp_vec(seq_state(i - 1), 8'd3));
            else if (i == 25) exp_q.push_back(exp_vec(3'd0, 8'd4));
            else exp_q.push_back(exp_vec(seq_state(i - 25), 8'd4));
            @(posedge clk);
            #1;
            soft_rst = 1'b0;
            if (i == 22) ext_rst = 1'b1;
            if (i == 23) ext_rst = 1'b0;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL ext_glitch edge %0d: got %h expected %h", i, obs, e);
            end
        end
    endtask

    task automatic test_async_rst();
        logic [14:0] e;
        soft_rst = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            exp_q.push_back(i == 1 ? exp_vec(3'd0, 8'd5) : exp_vec(seq_state(i - 1), 8'd5));
            @(posedge clk);
            #1;
            soft_rst = 1'b0;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL pre_abort edge %0d: got %h expected %h", i, obs, e);
            end
        end
        // Now in REL_CORE; reset lands between edges.
        #3;
        rst = 1'b1;
        exp_q.push_back(exp_vec(3'd0, 8'd0));
        #1;
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL async_abort: got %h expected %h", obs, e);
        end
        #2;
        rst = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            exp_q.push_back(exp_vec(seq_state(i), 8'd0));
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL post_abort edge %0d: got %h expected %h", i, obs, e);
            end
        end
    endtask

    task automatic test_saturate();
        logic [1:0] es;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        for (int i = 1; i <= 29; i++) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL sat_ready: got %b expected 1", s_ready);
        end
        for (int p = 0; p < 5; p++) begin
            soft_rst = 1'b1;
            sat_q.push_back((p < 3) ? 2'(p + 1) : 2'd3);
            for (int i = 1; i <= 30; i++) begin
                @(posedge clk);
                #1;
                soft_rst = 1'b0;
                if (i == 1) begin
                    es = sat_q.pop_front();
                    checks++;
                    if (s_evt !== es) begin
                        errors++;
                        $display("FAIL sat_evt pulse %0d: got %0d expected %0d", p, s_evt, es);
                    end
                    checks++;
                    if (evt !== 8'(p + 1)) begin
                        errors++;
                        $display("FAIL wide_evt pulse %0d: got %0d expected %0d", p, evt, p + 1);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_soft();
        test_ext();
        test_glitch();
        test_async_rst();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
